// File: rtl/nexys4_entry_pkg.sv
// Shared definitions for the Nexys4 manual word-entry block.
//   NIBBLES/NIBBLE_W/CURSOR_W/WORD_W : geometry of the edit buffer
//   ST_EDIT/ST_OFFER                 : entry FSM state encoding
//   nibble_op()                      : edit applied to the selected digit
package nexys4_entry_pkg;

  localparam int unsigned NIBBLES  = 8;
  localparam int unsigned CURSOR_W = 3;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned WORD_W   = NIBBLES * NIBBLE_W;

  localparam logic [0:0] ST_EDIT  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  // Up and down pressed together cancel out; digits wrap modulo 16.
  function automatic logic [NIBBLE_W-1:0] nibble_op(
    input logic [NIBBLE_W-1:0] cur_val,
    input logic                up,
    input logic                down,
    input logic                direct,
    input logic [NIBBLE_W-1:0] sw_val
  );
    if (up && !down)
      return direct ? sw_val : cur_val + 4'd1;
    else if (down && !up)
      return cur_val - 4'd1;
    else
      return cur_val;
  endfunction

endpackage

// File: rtl/nexys4_word_entry_if.sv
// Valid/ready handshake carrying the committed 32-bit word downstream.
//   word_out   : committed word, stable while word_valid is high
//   word_valid : word offered
//   word_ready : downstream accepts word_out
// master = word entry block, slave = consumer.
interface nexys4_word_entry_if import nexys4_entry_pkg::*; ();
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_out, output word_valid, input  word_ready);
  modport slave  (input  word_out, input  word_valid, output word_ready);
endinterface

// File: rtl/nexys4_word_entry_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debouncer and rise detector.
//   clk_in  : system clock
//   reset   : asynchronous, active-high
//   btn_i   : raw button level
//   rise_o  : one-cycle pulse when the debounced level goes 0 -> 1
// The debounced level follows the synchronised input only after it has
// disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle
// restarts the count.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk_in,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/nexys4_word_entry.sv
// Manual 32-bit word entry from Nexys4 buttons and switches.
//   clk_in, reset          : clock, asynchronous active-high reset
//   btn_left/right         : move nibble cursor toward MS / LS digit
//   btn_up/down            : increment (or direct-write) / decrement digit
//   btn_commit             : offer the edit buffer downstream
//   sw_nibble, sw_direct   : direct-write value and mode (synchronised)
//   edit_word, cursor      : live edit buffer and selected digit
//   bus (master)           : word_out / word_valid / word_ready handshake
module nexys4_word_entry import nexys4_entry_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_commit,
  input  logic [NIBBLE_W-1:0] sw_nibble,
  input  logic                sw_direct,
  output logic [WORD_W-1:0]   edit_word,
  output logic [CURSOR_W-1:0] cursor,
  nexys4_word_entry_if.master bus
);

  // Index order: 0 left, 1 right, 2 up, 3 down, 4 commit.
  logic [4:0] btn_raw;
  logic [4:0] pulse;

  assign btn_raw = {btn_commit, btn_down, btn_up, btn_right, btn_left};

  for (genvar g = 0; g < 5; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk_in(clk_in),
      .reset (reset),
      .btn_i (btn_raw[g]),
      .rise_o(pulse[g])
    );
  end

  logic [NIBBLE_W-1:0] swn_s1_q, swn_s2_q;
  logic                swd_s1_q, swd_s2_q;

  logic [0:0]          state_q, state_d;
  logic [WORD_W-1:0]   edit_q, edit_d;
  logic [CURSOR_W-1:0] cur_q, cur_d;
  logic [WORD_W-1:0]   wo_q, wo_d;

  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    cur_d   = cur_q;
    wo_d    = wo_q;
    case (state_q)
      ST_EDIT: begin
        if (pulse[4]) begin
          wo_d    = edit_q;
          state_d = ST_OFFER;
        end else begin
          // Digit edit uses the cursor as it was before this cycle's move.
          edit_d[{cur_q, 2'b00} +: NIBBLE_W] =
            nibble_op(edit_q[{cur_q, 2'b00} +: NIBBLE_W],
                      pulse[2], pulse[3], swd_s2_q, swn_s2_q);
          if (pulse[0] && !pulse[1])
            cur_d = cur_q + 3'd1;
          else if (pulse[1] && !pulse[0])
            cur_d = cur_q - 3'd1;
        end
      end
      ST_OFFER: begin
        if (bus.word_ready)
          state_d = ST_EDIT;
      end
      default: state_d = ST_EDIT;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      swn_s1_q <= '0;
      swn_s2_q <= '0;
      swd_s1_q <= 1'b0;
      swd_s2_q <= 1'b0;
      state_q  <= ST_EDIT;
      edit_q   <= '0;
      cur_q    <= '0;
      wo_q     <= '0;
    end else begin
      swn_s1_q <= sw_nibble;
      swn_s2_q <= swn_s1_q;
      swd_s1_q <= sw_direct;
      swd_s2_q <= swd_s1_q;
      state_q  <= state_d;
      edit_q   <= edit_d;
      cur_q    <= cur_d;
      wo_q     <= wo_d;
    end
  end

  assign edit_word      = edit_q;
  assign cursor         = cur_q;
  assign bus.word_out   = wo_q;
  assign bus.word_valid = (state_q == ST_OFFER);

endmodule

// File: tb/tb_nexys4_word_entry.sv
// Bench for nexys4_word_entry with a short debounce window.
module tb_nexys4_word_entry;

  localparam int D = 4;
  localparam int L = 0, R = 1, U = 2, DN = 3, C = 4;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic [4:0]  btn    = '0;
  logic [3:0]  sw_nibble = '0;
  logic        sw_direct = 1'b0;
  logic [31:0] edit_word;
  logic [2:0]  cursor;

  nexys4_word_entry_if bus ();

  nexys4_word_entry #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .btn_left  (btn[L]),
    .btn_right (btn[R]),
    .btn_up    (btn[U]),
    .btn_down  (btn[DN]),
    .btn_commit(btn[C]),
    .sw_nibble (sw_nibble),
    .sw_direct (sw_direct),
    .edit_word (edit_word),
    .cursor    (cursor),
    .bus       (bus)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- behavioural reference ----------------
  // hist[b][k] holds the raw button level seen k+1 edges ago; the
  // synchronised value at an edge is the raw level two edges earlier.
  bit          hist [5][0:D];
  bit          lvl  [5];
  bit          pend [5];
  logic [3:0]  swn_h [2];
  bit          swd_h [2];
  logic [31:0] m_edit = '0;
  logic [31:0] m_wo   = '0;
  int unsigned m_cur  = 0;
  bit          m_wv   = 1'b0;

  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 5; b++) begin
        for (int k = 0; k <= D; k++) hist[b][k] = 1'b0;
        lvl[b]  = 1'b0;
        pend[b] = 1'b0;
      end
      swn_h[0] = '0; swn_h[1] = '0;
      swd_h[0] = 1'b0; swd_h[1] = 1'b0;
      m_edit = '0; m_wo = '0; m_cur = 0; m_wv = 1'b0;
    end else begin
      logic [3:0] nib;
      if (m_wv) begin
        if (bus.word_ready) m_wv = 1'b0;
      end else if (pend[C]) begin
        m_wo = m_edit;
        m_wv = 1'b1;
      end else begin
        nib = 4'((m_edit >> (4 * m_cur)) & 32'hF);
        if (pend[U] && !pend[DN])
          nib = swd_h[1] ? swn_h[1] : 4'((int'(nib) + 1) % 16);
        else if (pend[DN] && !pend[U])
          nib = 4'((int'(nib) + 15) % 16);
        m_edit = (m_edit & ~(32'hF << (4 * m_cur))) | (32'(nib) << (4 * m_cur));
        if (pend[L] && !pend[R])      m_cur = (m_cur + 1) % 8;
        else if (pend[R] && !pend[L]) m_cur = (m_cur + 7) % 8;
      end
      for (int b = 0; b < 5; b++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int k = 1; k <= D; k++) if (hist[b][k] == lvl[b]) all_diff = 1'b0;
        pend[b] = 1'b0;
        if (all_diff) begin
          lvl[b]  = !lvl[b];
          pend[b] = lvl[b];
        end
        for (int k = D; k >= 1; k--) hist[b][k] = hist[b][k-1];
        hist[b][0] = btn[b];
      end
      swn_h[1] = swn_h[0]; swn_h[0] = sw_nibble;
      swd_h[1] = swd_h[0]; swd_h[0] = sw_direct;
    end
  end

  // ---------------- compare process ----------------
  int n_cmp = 0;
  int n_bad = 0;

  bit          lit_en = 1'b0;
  string       lit_name;
  logic [3:0]  lit_mask;   // bit0 edit_word, bit1 cursor, bit2 word_out, bit3 word_valid
  logic [31:0] lit_e, lit_wo;
  logic [2:0]  lit_c;
  logic        lit_wv;

  always @(negedge clk_in) begin
    n_cmp++;
    if (edit_word !== m_edit || cursor !== 3'(m_cur) ||
        bus.word_out !== m_wo || bus.word_valid !== m_wv) begin
      n_bad++;
      $display("FAIL model t=%0t: edit=%h want %h cur=%0d want %0d wo=%h want %h wv=%b want %b",
               $time, edit_word, m_edit, cursor, m_cur, bus.word_out, m_wo, bus.word_valid, m_wv);
    end
    if (lit_en) begin
      n_cmp++;
      if ((lit_mask[0] && edit_word !== lit_e) || (lit_mask[1] && cursor !== lit_c) ||
          (lit_mask[2] && bus.word_out !== lit_wo) || (lit_mask[3] && bus.word_valid !== lit_wv)) begin
        n_bad++;
        $display("FAIL %s: edit=%h want %h cur=%0d want %0d wo=%h want %h wv=%b want %b (mask %b)",
                 lit_name, edit_word, lit_e, cursor, lit_c, bus.word_out, lit_wo,
                 bus.word_valid, lit_wv, lit_mask);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  task automatic press(input logic [4:0] m, input int hold);
    btn = m;
    step(hold);
    btn = '0;
    step(D + 6);
  endtask

  task automatic lit(input string name, input logic [3:0] mask, input logic [31:0] e,
                     input logic [2:0] c, input logic [31:0] wo, input logic wv);
    lit_name = name; lit_mask = mask;
    lit_e = e; lit_c = c; lit_wo = wo; lit_wv = wv;
    lit_en = 1'b1;
    @(negedge clk_in);
    #1;
    lit_en = 1'b0;
    step(1);
  endtask

  initial begin
    logic [31:0] target;
    int unsigned run [5];

    bus.word_ready = 1'b0;
    step(3);
    reset = 1'b0;
    step(2);
    lit("reset", 4'hF, 32'h0, 3'd0, 32'h0, 1'b0);

    press(5'b00100, 10);
    lit("up_once", 4'h3, 32'h00000001, 3'd0, 32'h0, 1'b0);

    btn[U] = 1'b1; step(3); btn = '0; step(10);
    lit("glitch", 4'h3, 32'h00000001, 3'd0, 32'h0, 1'b0);

    repeat (15) press(5'b00100, 8);
    lit("up_wrap", 4'h3, 32'h00000000, 3'd0, 32'h0, 1'b0);
    press(5'b01000, 8);
    lit("down_wrap", 4'h3, 32'h0000000F, 3'd0, 32'h0, 1'b0);
    press(5'b00010, 8);
    lit("right_wrap", 4'h2, 32'h0, 3'd7, 32'h0, 1'b0);
    press(5'b00001, 8);
    lit("left_wrap", 4'h2, 32'h0, 3'd0, 32'h0, 1'b0);
    repeat (7) press(5'b00001, 8);
    lit("left7", 4'h3, 32'h0000000F, 3'd7, 32'h0, 1'b0);

    sw_direct = 1'b1; sw_nibble = 4'hA; step(3);
    press(5'b00100, 8);
    lit("direct", 4'h3, 32'hA000000F, 3'd7, 32'h0, 1'b0);

    target = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) begin
      sw_nibble = target[31 - 4*i -: 4];
      step(3);
      press(5'b00100, 8);
      press(5'b00010, 8);
    end
    sw_direct = 1'b0;
    lit("built", 4'h3, 32'hDEADBEEF, 3'd7, 32'h0, 1'b0);

    press(5'b10000, 8);
    lit("offer", 4'hC, 32'h0, 3'd0, 32'hDEADBEEF, 1'b1);
    press(5'b00101, 8);
    step(4);
    lit("offer_hold", 4'hF, 32'hDEADBEEF, 3'd7, 32'hDEADBEEF, 1'b1);
    bus.word_ready = 1'b1;
    step(1);
    lit("transfer", 4'h8, 32'h0, 3'd0, 32'h0, 1'b0);
    bus.word_ready = 1'b0;

    press(5'b10101, 8);
    lit("commit_prio", 4'hF, 32'hDEADBEEF, 3'd7, 32'hDEADBEEF, 1'b1);
    bus.word_ready = 1'b1; step(2); bus.word_ready = 1'b0;
    press(5'b01100, 8);
    lit("up_down", 4'h9, 32'hDEADBEEF, 3'd7, 32'h0, 1'b0);
    press(5'b00011, 8);
    lit("left_right", 4'hB, 32'hDEADBEEF, 3'd7, 32'h0, 1'b0);

    press(5'b10000, 8);
    lit("offer2", 4'h8, 32'h0, 3'd0, 32'h0, 1'b1);
    reset = 1'b1;
    lit_name = "reset_offer"; lit_mask = 4'hF;
    lit_e = '0; lit_c = '0; lit_wo = '0; lit_wv = 1'b0;
    lit_en = 1'b1;
    @(negedge clk_in); #1; lit_en = 1'b0;
    btn[U] = 1'b1;
    step(2);
    reset = 1'b0;
    step(12);
    lit("held_through_reset", 4'h3, 32'h00000001, 3'd0, 32'h0, 1'b0);
    btn = '0;
    step(10);

    for (int b = 0; b < 5; b++) run[b] = 0;
    repeat (3000) begin
      for (int b = 0; b < 5; b++) begin
        if (run[b] == 0) begin
          btn[b] = ($urandom_range(0, 99) < ((b == C) ? 15 : 45));
          run[b] = $urandom_range(1, 12);
        end
        run[b]--;
      end
      bus.word_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) sw_nibble = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) sw_direct = ~sw_direct;
      reset = ($urandom_range(0, 599) == 0);
      step(1);
    end
    reset = 1'b0;
    btn = '0;
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
